// File: rtl/vpu_lane_array.sv
// SIZE-lane Q8.8 post-processing pipeline: bias add, then leaky-ReLU or its derivative.
// Three registered stages per lane, a sticky saturation flag and a pipeline-busy output.
module vpu_lane_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SIZE   = 8,
  parameter int unsigned FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               vpu_data_pathway,
  input  logic [DATA_W*SIZE-1:0]   vpu_data_in,
  input  logic [SIZE-1:0]          vpu_valid_in,
  input  logic [DATA_W*SIZE-1:0]   bias_scalar_in,
  input  logic [DATA_W-1:0]        lr_leak_factor_in,
  output logic [DATA_W*SIZE-1:0]   vpu_data_out,
  output logic [SIZE-1:0]          vpu_valid_out,
  output logic                     sat_flag,
  input  logic                     sat_clr,
  output logic                     vpu_pipe_busy
);

  localparam int unsigned SUM_W  = DATA_W + 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] ONE_V = DATA_W'(2**FRAC_W);
  localparam logic signed [PROD_W-1:0] RND_V = PROD_W'(2**(FRAC_W-1));

  logic [DATA_W-1:0] z_c [SIZE];
  logic [DATA_W-1:0] b_c [SIZE];

  // S1: biased sample plus the op bits and leak it travels with
  logic signed [DATA_W-1:0] s1_data_q [SIZE];
  logic signed [DATA_W-1:0] s1_data_d [SIZE];
  logic [SIZE-1:0]          s1_valid_q, s1_valid_d;
  logic [1:0]               s1_path_q, s1_path_d;
  logic signed [DATA_W-1:0] s1_leak_q, s1_leak_d;

  // S2: activation result
  logic signed [DATA_W-1:0] s2_data_q [SIZE];
  logic signed [DATA_W-1:0] s2_data_d [SIZE];
  logic [SIZE-1:0]          s2_valid_q, s2_valid_d;

  // S3: output register
  logic [DATA_W-1:0]        out_data_q [SIZE];
  logic [DATA_W-1:0]        out_data_d [SIZE];
  logic [SIZE-1:0]          out_valid_q, out_valid_d;

  logic sat_q, sat_d;
  logic busy_q, busy_d;

  logic [SUM_W-1:0]         sum_c;
  logic signed [DATA_W-1:0] s_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] scaled_c;
  logic signed [DATA_W-1:0] leaky_c;
  logic                     leaky_clip_c;
  logic signed [DATA_W-1:0] r_c;
  logic                     sat_set_c;
  logic                     unused_pathway_c;

  assign unused_pathway_c = vpu_data_pathway[3];

  for (genvar g = 0; g < SIZE; g++) begin : g_lane_io
    assign z_c[g] = vpu_data_in[g*DATA_W +: DATA_W];
    assign b_c[g] = bias_scalar_in[g*DATA_W +: DATA_W];
    assign vpu_data_out[g*DATA_W +: DATA_W] = out_data_q[g];
  end

  always_comb begin
    sat_set_c    = 1'b0;
    sum_c        = '0;
    s_c          = '0;
    prod_c       = '0;
    scaled_c     = '0;
    leaky_c      = '0;
    leaky_clip_c = 1'b0;
    r_c          = '0;
    s1_valid_d   = vpu_valid_in;
    s1_path_d    = vpu_data_pathway[2:1];
    s1_leak_d    = lr_leak_factor_in;
    s2_valid_d   = s1_valid_q;
    out_valid_d  = s2_valid_q;
    for (int i = 0; i < SIZE; i++) begin
      // S1: 17-bit bias add with clip to the 16-bit range
      sum_c = {z_c[i][DATA_W-1], z_c[i]} +
              (vpu_data_pathway[0] ? {b_c[i][DATA_W-1], b_c[i]} : SUM_W'(0));
      if (sum_c[DATA_W] != sum_c[DATA_W-1]) begin
        s1_data_d[i] = sum_c[DATA_W] ? MIN_V : MAX_V;
        if (vpu_valid_in[i]) sat_set_c = 1'b1;
      end else begin
        s1_data_d[i] = sum_c[DATA_W-1:0];
      end

      // S2: negative branch scales by leak with round-half-up, then clips
      s_c      = s1_data_q[i];
      prod_c   = PROD_W'(s_c) * PROD_W'(s1_leak_q);
      scaled_c = (prod_c + RND_V) >>> FRAC_W;
      leaky_clip_c = 1'b1;
      if (scaled_c > PROD_W'(MAX_V))      leaky_c = MAX_V;
      else if (scaled_c < PROD_W'(MIN_V)) leaky_c = MIN_V;
      else begin
        leaky_c      = scaled_c[DATA_W-1:0];
        leaky_clip_c = 1'b0;
      end

      if (s1_path_q[1]) begin
        r_c = s_c[DATA_W-1] ? s1_leak_q : ONE_V;
      end else if (s1_path_q[0] && s_c[DATA_W-1]) begin
        r_c = leaky_c;
        if (leaky_clip_c && s1_valid_q[i]) sat_set_c = 1'b1;
      end else begin
        r_c = s_c;
      end
      s2_data_d[i] = r_c;

      out_data_d[i] = s2_valid_q[i] ? s2_data_q[i] : '0;
    end
    busy_d = (|s1_valid_d) | (|s2_valid_d) | (|out_valid_d);
    sat_d  = sat_set_c | (sat_q & ~sat_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        s1_data_q[i]  <= '0;
        s2_data_q[i]  <= '0;
        out_data_q[i] <= '0;
      end
      s1_valid_q  <= '0;
      s1_path_q   <= '0;
      s1_leak_q   <= '0;
      s2_valid_q  <= '0;
      out_valid_q <= '0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        s1_data_q[i]  <= s1_data_d[i];
        s2_data_q[i]  <= s2_data_d[i];
        out_data_q[i] <= out_data_d[i];
      end
      s1_valid_q  <= s1_valid_d;
      s1_path_q   <= s1_path_d;
      s1_leak_q   <= s1_leak_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      busy_q      <= busy_d;
    end
  end

  assign vpu_valid_out = out_valid_q;
  assign sat_flag      = sat_q;
  assign vpu_pipe_busy = busy_q;

endmodule

// File: tb/tb_vpu_lane_array.sv
// Scoreboard bench for vpu_lane_array: driver queues expected output vectors with their
// emergence cycle; a negedge monitor pops and compares whenever any lane is valid.
module tb_vpu_lane_array;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   pathway;
  logic [127:0] data_in;
  logic [7:0]   valid_in;
  logic [127:0] bias_in;
  logic [15:0]  leak;
  logic [127:0] data_out;
  logic [7:0]   valid_out;
  logic         sat_flag;
  logic         sat_clr;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] data;
    logic [7:0]   valid;
    int           cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] vz [8];
  logic [15:0] vb [8];
  logic [15:0] ve [8];

  vpu_lane_array dut (
    .clk               (clk),
    .rst               (rst),
    .vpu_data_pathway  (pathway),
    .vpu_data_in       (data_in),
    .vpu_valid_in      (valid_in),
    .bias_scalar_in    (bias_in),
    .lr_leak_factor_in (leak),
    .vpu_data_out      (data_out),
    .vpu_valid_out     (valid_out),
    .sat_flag          (sat_flag),
    .sat_clr           (sat_clr),
    .vpu_pipe_busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid output vector must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && valid_out != 8'h00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: cyc=%0d valid=%h data=%h, expected no output", cyc, valid_out, data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (data_out !== e.data || valid_out !== e.valid || cyc != e.cyc) begin
          errors++;
          $display("FAIL scoreboard: got cyc=%0d valid=%h data=%h, expected cyc=%0d valid=%h data=%h",
                   cyc, valid_out, data_out, e.cyc, e.valid, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [3:0] p, input logic [15:0] z, input logic [15:0] b,
                                        input logic [15:0] lk);
    longint s, r;
    s = longint'($signed(z));
    if (p[0]) s = s + longint'($signed(b));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (p[2]) r = (s >= 0) ? 256 : longint'($signed(lk));
    else if (p[1] && s < 0) begin
      r = (s * longint'($signed(lk)) + 128) >>> 8;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
    end else r = s;
    return 16'(r);
  endfunction

  task automatic fill(input logic [15:0] z, input logic [15:0] b, input logic [15:0] e);
    for (int i = 0; i < 8; i++) begin
      vz[i] = z; vb[i] = b; ve[i] = e;
    end
  endtask

  task automatic send(input logic [3:0] p, input logic [15:0] lk, input logic [7:0] vm, input logic clr);
    exp_t e;
    @(negedge clk);
    pathway  = p;
    leak     = lk;
    valid_in = vm;
    sat_clr  = clr;
    e.data   = '0;
    for (int i = 0; i < 8; i++) begin
      data_in[i*16 +: 16] = vz[i];
      bias_in[i*16 +: 16] = vb[i];
      if (vm[i]) e.data[i*16 +: 16] = ve[i];
    end
    e.valid = vm;
    e.cyc   = cyc + 3;
    if (vm != 8'h00) exp_q.push_back(e);
  endtask

  // Idle cycles scramble op bits and leak to show samples carry their own copies
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      valid_in = 8'h00;
      sat_clr  = 1'b0;
      pathway  = 4'b0111;
      leak     = 16'h7FFF;
      data_in  = {8{16'h8001}};
      bias_in  = {8{16'h8001}};
    end
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    valid_in = 8'h00;
    sat_clr  = 1'b1;
    idle(1);
  endtask

  initial begin
    rst = 1'b1; pathway = '0; data_in = '0; valid_in = '0; bias_in = '0; leak = '0; sat_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_data",  data_out, 128'h0);
    chk("reset_valid", 128'(valid_out), 128'h0);
    chk("reset_sat",   128'(sat_flag), 128'h0);
    chk("reset_busy",  128'(busy), 128'h0);
    rst = 1'b0;
    idle(2);

    // Bias + leaky on positive value; idle lanes carry would-be clipping data
    fill(16'h0200, 16'h0080, 16'h0280);
    for (int i = 1; i < 8; i++) begin vz[i] = 16'h7F00; vb[i] = 16'h0200; end
    send(4'b0011, 16'h001A, 8'h01, 1'b0);
    idle(4);
    chk("t1_sat_quiet", 128'(sat_flag), 128'h0);

    // Leaky-ReLU
    fill(16'hFE00, 16'h0000, 16'hFFCC); send(4'b0010, 16'h001A, 8'hFF, 1'b0);
    fill(16'h0000, 16'h0000, 16'h0000); send(4'b0010, 16'h001A, 8'hFF, 1'b0);
    fill(16'h0150, 16'h0000, 16'h0150); send(4'b0010, 16'h001A, 8'hA5, 1'b0);
    fill(16'hFFFF, 16'h0000, 16'h0000); send(4'b0010, 16'h0080, 8'h3C, 1'b0);
    fill(16'hFE00, 16'h0100, 16'hFFE6); send(4'b0011, 16'h001A, 8'hFF, 1'b0);
    idle(4);
    chk("t2_sat_quiet", 128'(sat_flag), 128'h0);

    // Bias saturation, clear, and set-wins-over-clear
    fill(16'h7F00, 16'h0200, 16'h7FFF); send(4'b0001, 16'h001A, 8'h01, 1'b0);
    idle(4);
    chk("t3_sat_pos", 128'(sat_flag), 128'h1);
    clr_pulse();
    chk("t3_sat_clr", 128'(sat_flag), 128'h0);
    fill(16'h8000, 16'hFF00, 16'h8000); send(4'b0001, 16'h001A, 8'h80, 1'b0);
    idle(1);
    chk("t3_sat_neg", 128'(sat_flag), 128'h1);
    fill(16'h7F00, 16'h0200, 16'h7FFF); send(4'b0001, 16'h001A, 8'h02, 1'b1);
    idle(1);
    chk("t3_set_wins", 128'(sat_flag), 128'h1);
    idle(3);
    clr_pulse();
    chk("t3_sat_clr2", 128'(sat_flag), 128'h0);
    // Clip in the activation stage
    fill(16'h8000, 16'h0000, 16'h7FFF); send(4'b0010, 16'h8000, 8'h01, 1'b0);
    idle(4);
    chk("t3_sat_act", 128'(sat_flag), 128'h1);
    clr_pulse();

    // Derivative priority, pass-through, reserved bit ignored
    fill(16'hFF00, 16'h0000, 16'h001A); send(4'b0110, 16'h001A, 8'hFF, 1'b0);
    fill(16'h0100, 16'h0000, 16'h0100); send(4'b0110, 16'h001A, 8'hFF, 1'b0);
    fill(16'h0000, 16'h0000, 16'h0100); send(4'b0110, 16'h001A, 8'hFF, 1'b0);
    fill(16'h1234, 16'h5555, 16'h1234); send(4'b0000, 16'h001A, 8'hFF, 1'b0);
    fill(16'h8000, 16'h7FFF, 16'h8000); send(4'b1000, 16'h001A, 8'h0F, 1'b0);
    idle(4);
    chk("t4_busy_idle", 128'(busy), 128'h0);

    // Back-to-back stream with pathway changing every vector
    for (int k = 0; k < 8; k++) begin
      logic [3:0]  p;
      logic [15:0] lk;
      p  = (k == 5) ? 4'b0110 : ((k % 2 == 0) ? 4'b0011 : 4'b0001);
      lk = 16'(16'h0040 + k);
      for (int i = 0; i < 8; i++) begin
        vz[i] = 16'((i - 4) * 300 + k * 50);
        vb[i] = 16'(k * 16 - 40);
        ve[i] = model(p, vz[i], vb[i], lk);
      end
      send(p, lk, 8'hFF, 1'b0);
    end
    idle(1);
    chk("t5_busy_c1", 128'(busy), 128'h1);
    idle(1);
    chk("t5_busy_c2", 128'(busy), 128'h1);
    idle(1);
    chk("t5_busy_c3", 128'(busy), 128'h1);
    idle(1);
    chk("t5_busy_drop", 128'(busy), 128'h0);
    idle(2);

    // Reset with samples in flight
    fill(16'h0300, 16'h0000, 16'h0300); send(4'b0000, 16'h001A, 8'hFF, 1'b0);
    fill(16'h7F00, 16'h0200, 16'h7FFF); send(4'b0001, 16'h001A, 8'hFF, 1'b0);
    fill(16'h0100, 16'h0000, 16'h0100); send(4'b0000, 16'h001A, 8'hFF, 1'b0);
    @(negedge clk);
    valid_in = 8'h00;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_rst_data",  data_out, 128'h0);
    chk("t6_rst_valid", 128'(valid_out), 128'h0);
    chk("t6_rst_busy",  128'(busy), 128'h0);
    chk("t6_rst_sat",   128'(sat_flag), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic [7:0] seen;
      seen = 8'h00;
      for (int k = 0; k < 6; k++) begin
        idle(1);
        seen = seen | valid_out;
      end
      chk("t6_nothing_after", 128'(seen), 128'h0);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected vectors never emerged, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
